// File: rtl/collatz_sweep.sv
// collatz_sweep: walks every value of an inclusive 8-bit range through the
// Collatz step-count unit (ABC) and reports the value with the largest step
// count. Ties keep the smaller value.
//
// Handshake (requester side and ABC side alike, 4-phase soc/eoc):
//   soc rises to request work; eoc falls to acknowledge; soc falls;
//   eoc rises when the result is valid and stays high until the next soc.
module collatz_sweep (
    input  logic       clock,
    input  logic       reset,
    input  logic       soc,
    output logic       eoc,
    input  logic [7:0] lo,
    input  logic [7:0] hi,
    output logic [7:0] best_n,
    output logic [7:0] best_k,
    output logic [7:0] abc_n_0,
    output logic       abc_soc,
    input  logic       abc_eoc,
    input  logic [7:0] abc_k,
    output logic [2:0] debug_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CHK  = 3'd1,
        S_SOC  = 3'd2,
        S_WACK = 3'd3,
        S_WRES = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] lo_r, lo_nxt;
    logic [7:0] hi_r, hi_nxt;
    logic [7:0] cur, cur_nxt;
    logic       first, first_nxt;
    logic       eoc_nxt;
    logic       abc_soc_nxt;
    logic [7:0] abc_n_0_nxt;
    logic [7:0] best_n_nxt;
    logic [7:0] best_k_nxt;

    assign debug_state = state;

    // State and every output register; reset restores the idle picture.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            lo_r    <= 8'd0;
            hi_r    <= 8'd0;
            cur     <= 8'd0;
            first   <= 1'b0;
            eoc     <= 1'b1;
            abc_soc <= 1'b0;
            abc_n_0 <= 8'd0;
            best_n  <= 8'd0;
            best_k  <= 8'd0;
        end else begin
            state   <= state_nxt;
            lo_r    <= lo_nxt;
            hi_r    <= hi_nxt;
            cur     <= cur_nxt;
            first   <= first_nxt;
            eoc     <= eoc_nxt;
            abc_soc <= abc_soc_nxt;
            abc_n_0 <= abc_n_0_nxt;
            best_n  <= best_n_nxt;
            best_k  <= best_k_nxt;
        end
    end

    // Next-state and next register values; everything holds unless a state acts.
    always_comb begin
        state_nxt   = state;
        lo_nxt      = lo_r;
        hi_nxt      = hi_r;
        cur_nxt     = cur;
        first_nxt   = first;
        eoc_nxt     = eoc;
        abc_soc_nxt = abc_soc;
        abc_n_0_nxt = abc_n_0;
        best_n_nxt  = best_n;
        best_k_nxt  = best_k;

        unique case (state)
            S_IDLE: begin
                if (soc) begin
                    // Zero has no Collatz sequence, so the sweep starts at 1.
                    lo_nxt    = (lo == 8'd0) ? 8'd1 : lo;
                    hi_nxt    = hi;
                    eoc_nxt   = 1'b0;
                    state_nxt = S_CHK;
                end
            end
            S_CHK: begin
                if (lo_r > hi_r) begin
                    best_n_nxt = 8'd0;
                    best_k_nxt = 8'd0;
                    state_nxt  = S_DONE;
                end else begin
                    cur_nxt     = lo_r;
                    abc_n_0_nxt = lo_r;
                    first_nxt   = 1'b1;
                    state_nxt   = S_SOC;
                end
            end
            S_SOC: begin
                // abc_n_0 was loaded a cycle earlier, so it is settled here.
                abc_soc_nxt = 1'b1;
                state_nxt   = S_WACK;
            end
            S_WACK: begin
                if (!abc_eoc) begin
                    abc_soc_nxt = 1'b0;
                    state_nxt   = S_WRES;
                end
            end
            S_WRES: begin
                if (abc_eoc) begin
                    // Strict greater-than keeps the earlier (smaller) value on ties.
                    if (first || (abc_k > best_k)) begin
                        best_k_nxt = abc_k;
                        best_n_nxt = cur;
                        first_nxt  = 1'b0;
                    end
                    // End test before the increment so hi = 255 cannot wrap.
                    if (cur == hi_r) begin
                        state_nxt = S_DONE;
                    end else begin
                        cur_nxt     = cur + 8'd1;
                        abc_n_0_nxt = cur + 8'd1;
                        state_nxt   = S_SOC;
                    end
                end
            end
            S_DONE: begin
                if (!soc) begin
                    eoc_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_collatz_sweep.sv
// Directed bench for collatz_sweep with a behavioural ABC responder.
module tb_collatz_sweep;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CHK  = 3'd1;
    localparam logic [2:0] ST_DONE = 3'd5;
    // Cycles the responder adds per value beyond the controller's own three.
    localparam int ABC_T = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       soc   = 1'b0;
    logic       eoc;
    logic [7:0] lo    = 8'd0;
    logic [7:0] hi    = 8'd0;
    logic [7:0] best_n;
    logic [7:0] best_k;
    logic [7:0] abc_n_0;
    logic       abc_soc;
    logic       abc_eoc = 1'b1;
    logic [7:0] abc_k   = 8'd0;
    logic [2:0] debug_state;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int         txn_count = 0;
    logic       abc_busy  = 1'b0;
    logic [7:0] abc_cur_n = 8'd0;
    int         abc_cnt   = 0;
    int         abc_res   = 0;

    collatz_sweep dut (
        .clock       (clock),
        .reset       (reset),
        .soc         (soc),
        .eoc         (eoc),
        .lo          (lo),
        .hi          (hi),
        .best_n      (best_n),
        .best_k      (best_k),
        .abc_n_0     (abc_n_0),
        .abc_soc     (abc_soc),
        .abc_eoc     (abc_eoc),
        .abc_k       (abc_k),
        .debug_state (debug_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int collatz_k(input int n);
        int k;
        int v;
        k = 0;
        v = n;
        if (v <= 0) return 0;
        while (v != 1) begin
            if (v % 2 == 1) v = 3 * v + 1;
            else v = v / 2;
            k++;
        end
        return k;
    endfunction

    // ABC responder: accepts on soc, drops eoc, counts down, returns k once soc is low.
    always @(posedge clock) begin
        if (reset) begin
            abc_busy = 1'b0;
            #1;
            abc_eoc = 1'b1;
            abc_k   = 8'd0;
        end else if (!abc_busy) begin
            if (abc_soc) begin
                abc_cur_n = abc_n_0;
                abc_res   = collatz_k(int'(abc_n_0));
                abc_cnt   = 2;
                abc_busy  = 1'b1;
                txn_count++;
                check("abc_txn_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("abc_n_0_order", abc_n_0, exp_q.pop_front());
                #1;
                abc_eoc = 1'b0;
            end
        end else begin
            check("abc_n_0_stable", abc_n_0, abc_cur_n);
            if (!abc_soc && abc_cnt == 0) begin
                abc_busy = 1'b0;
                #1;
                abc_k   = abc_res[7:0];
                abc_eoc = 1'b1;
            end else if (abc_cnt > 0) begin
                abc_cnt--;
            end
        end
    end

    task automatic run_sweep(input string tag, input int l, input int h,
                             input int exp_n, input int exp_k);
        int first_v;
        int n_vals;
        int cycles;
        first_v = (l == 0) ? 1 : l;
        exp_q.delete();
        for (int v = first_v; v <= h; v++) exp_q.push_back(v[7:0]);
        n_vals    = exp_q.size();
        txn_count = 0;

        @(negedge clock);
        lo  = l[7:0];
        hi  = h[7:0];
        soc = 1'b1;
        @(posedge clock); #1;
        check({tag, "_eoc_fall"}, eoc, 0);
        check({tag, "_enter_chk"}, debug_state, ST_CHK);
        lo = 8'($urandom_range(0, 255));
        hi = 8'($urandom_range(0, 255));
        cycles = 1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock); #1;
            cycles++;
            if (debug_state == ST_DONE) break;
        end
        check({tag, "_done_reached"}, debug_state, ST_DONE);
        check({tag, "_latency"}, cycles, 2 + n_vals * (3 + ABC_T));
        repeat (2) @(posedge clock);
        #1;
        check({tag, "_eoc_held_in_done"}, eoc, 0);
        @(negedge clock);
        soc = 1'b0;
        @(posedge clock); #1;
        check({tag, "_eoc_rise"}, eoc, 1);
        check({tag, "_back_idle"}, debug_state, ST_IDLE);
        check({tag, "_best_n"}, best_n, exp_n);
        check({tag, "_best_k"}, best_k, exp_k);
        check({tag, "_txn_count"}, txn_count, n_vals);
        check({tag, "_queue_drained"}, exp_q.size(), 0);
        repeat (3) @(posedge clock);
        #1;
        check({tag, "_best_n_stable"}, best_n, exp_n);
        check({tag, "_abc_soc_idle"}, abc_soc, 0);
    endtask

    initial begin
        int hit;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            check("rst_eoc", eoc, 1);
            check("rst_abc_soc", abc_soc, 0);
            check("rst_best_n", best_n, 0);
            check("rst_best_k", best_k, 0);
        end
        check("rst_abc_n_0", abc_n_0, 0);

        run_sweep("single27", 27, 27, 27, 111);
        run_sweep("one_to_ten", 1, 10, 9, 19);
        run_sweep("tie_12_13", 12, 13, 12, 9);
        run_sweep("lo_zero", 0, 3, 3, 7);
        run_sweep("empty", 5, 4, 0, 0);
        run_sweep("range_end", 250, 255, 250, 109);
        run_sweep("full", 1, 255, 231, 127);

        // Reset while n = 100 is in flight at the ABC.
        exp_q.delete();
        for (int v = 95; v <= 120; v++) exp_q.push_back(v[7:0]);
        @(negedge clock);
        lo  = 8'd95;
        hi  = 8'd120;
        soc = 1'b1;
        hit = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clock); #1;
            if (abc_busy && abc_cur_n == 8'd100) begin
                hit = 1;
                break;
            end
        end
        check("mid_reach_n100", hit, 1);
        @(negedge clock);
        reset = 1'b1;
        soc   = 1'b0;
        @(posedge clock); #1;
        check("mid_rst_eoc", eoc, 1);
        check("mid_rst_abc_soc", abc_soc, 0);
        check("mid_rst_abc_n_0", abc_n_0, 0);
        check("mid_rst_best_n", best_n, 0);
        check("mid_rst_best_k", best_k, 0);
        check("mid_rst_state", debug_state, ST_IDLE);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clock);

        run_sweep("restart7", 7, 7, 7, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
